// File: rtl/vga_pkg.sv
// Shared scan-controller state encoding and the 640x480@60 default timing.
package vga_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } scan_state_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with active/sync decode.
module vga_axis_counter #(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48
) (
    input  logic                                   clk,
    input  logic                                   rst_i,
    input  logic                                   adv_i,
    output logic [$clog2(ACTIVE+FP+SYNC+BP)-1:0]   count_o,
    output logic                                   active_o,
    output logic                                   sync_o,
    output logic                                   wrap_o
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam int CW    = $clog2(TOTAL);
    localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_last;

    assign at_last = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (adv_i)
            cnt_d = at_last ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // Decode in 32 bits so a zero back porch cannot overflow the bounds.
    assign count_o  = cnt_q;
    assign wrap_o   = adv_i && at_last;
    assign active_o = 32'(cnt_q) < ACTIVE;
    assign sync_o   = (32'(cnt_q) >= ACTIVE + FP) && (32'(cnt_q) < ACTIVE + FP + SYNC);

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster generator: pixel-rate divider, run/drain control, two-stage
// request/colour pipeline with syncs aligned to the returned colour.
module vga_scan_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   RW       = 3,
    parameter int   GW       = 3,
    parameter int   BW       = 2,
    parameter int   PIX_DIV  = 2
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          Enable,
    input  logic [RW+GW+BW-1:0]           PixelData,
    output logic                          PixelReq,
    output logic [$clog2(H_ACTIVE)-1:0]   PixelX,
    output logic [$clog2(V_ACTIVE)-1:0]   PixelY,
    output logic [RW-1:0]                 Red,
    output logic [GW-1:0]                 Green,
    output logic [BW-1:0]                 Blue,
    output logic                          HS,
    output logic                          VS,
    output logic                          FrameStart
);

    localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);
    localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    scan_state_t    state_q, state_d;
    logic [DW-1:0]  div_q, div_d;
    logic           running, tick, adv;
    logic [HW-1:0]  hcnt;
    logic [VW-1:0]  vcnt;
    logic           h_act, h_sync, h_wrap;
    logic           v_act, v_sync, v_wrap;

    // Stage 1 (request) and stage 2 (colour/sync) registers.
    logic           req_q, fs_q, act_q, hsf_q, vsf_q;
    logic [XW-1:0]  x_q;
    logic [YW-1:0]  y_q;
    logic [RW-1:0]  r_q;
    logic [GW-1:0]  g_q;
    logic [BW-1:0]  b_q;
    logic           hs_q, vs_q;

    assign running = (state_q != ST_IDLE);
    assign tick    = (div_q == DW'(PIX_DIV - 1));
    assign adv     = running && tick;

    always_comb begin
        div_d = div_q;
        if (running)
            div_d = tick ? '0 : div_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (Enable) state_d = ST_RUN;
            ST_RUN:   if (!Enable) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (Enable)      state_d = ST_RUN;
                else if (v_wrap) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
        end
    end

    vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
        .clk(Clk), .rst_i(Reset), .adv_i(adv),
        .count_o(hcnt), .active_o(h_act), .sync_o(h_sync), .wrap_o(h_wrap)
    );

    vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
        .clk(Clk), .rst_i(Reset), .adv_i(h_wrap),
        .count_o(vcnt), .active_o(v_act), .sync_o(v_sync), .wrap_o(v_wrap)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            req_q <= 1'b0; fs_q  <= 1'b0; x_q   <= '0;    y_q   <= '0;
            act_q <= 1'b0; hsf_q <= 1'b0; vsf_q <= 1'b0;
            r_q   <= '0;   g_q   <= '0;   b_q   <= '0;
            hs_q  <= ~HS_POL; vs_q <= ~VS_POL;
        end else begin
            req_q <= adv && h_act && v_act;
            fs_q  <= adv && (hcnt == '0) && (vcnt == '0);
            if (adv) begin
                x_q   <= hcnt[XW-1:0];
                y_q   <= vcnt[YW-1:0];
                act_q <= h_act && v_act;
                hsf_q <= h_sync;
                vsf_q <= v_sync;
                // Stage 2 consumes the data answering the previous tick's request.
                r_q   <= act_q ? PixelData[RW+GW+BW-1 -: RW] : '0;
                g_q   <= act_q ? PixelData[GW+BW-1 -: GW]    : '0;
                b_q   <= act_q ? PixelData[BW-1:0]           : '0;
                hs_q  <= ~(hsf_q ^ HS_POL);
                vs_q  <= ~(vsf_q ^ VS_POL);
            end else if (!running) begin
                act_q <= 1'b0; hsf_q <= 1'b0; vsf_q <= 1'b0;
                r_q   <= '0;   g_q   <= '0;   b_q   <= '0;
                hs_q  <= ~HS_POL; vs_q <= ~VS_POL;
            end
        end
    end

    assign PixelReq   = req_q;
    assign FrameStart = fs_q;
    assign PixelX     = x_q;
    assign PixelY     = y_q;
    assign Red        = r_q;
    assign Green      = g_q;
    assign Blue       = b_q;
    assign HS         = hs_q;
    assign VS         = vs_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench: small-timing instance against a linear-raster reference model,
// plus a default-timing instance for pixel-divider and line timing.
module tb_vga_scan_gen;

    localparam int HA = 4, HF = 1, HSY = 2, HB = 1;
    localparam int VA = 3, VF = 1, VSY = 1, VB = 1;
    localparam int HT = HA + HF + HSY + HB;
    localparam int VT = VA + VF + VSY + VB;

    logic       clk, rst, en, en2;
    logic [7:0] pd, pd2;
    logic       req, fs, hs, vs;
    logic [1:0] px, py, b;
    logic [2:0] r, g;
    logic       req2, fs2, hs2, vs2;
    logic [9:0] px2;
    logic [8:0] py2;
    logic [2:0] r2, g2;
    logic [1:0] b2;

    int checks = 0, failures = 0, cyc = 0;

    vga_scan_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .PIX_DIV(1)) u_small (
        .Clk(clk), .Reset(rst), .Enable(en), .PixelData(pd), .PixelReq(req),
        .PixelX(px), .PixelY(py), .Red(r), .Green(g), .Blue(b), .HS(hs), .VS(vs), .FrameStart(fs));

    vga_scan_gen #(.PIX_DIV(2)) u_dflt (
        .Clk(clk), .Reset(rst), .Enable(en2), .PixelData(pd2), .PixelReq(req2),
        .PixelX(px2), .PixelY(py2), .Red(r2), .Green(g2), .Blue(b2), .HS(hs2), .VS(vs2), .FrameStart(fs2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: raster walked as a linear pixel index; scanning stops at
    // the frame boundary only if Enable was low on both of the last two edges.
    bit         m_run, m_enp, m_act, m_hsy, m_vsy;
    int         m_pos;
    logic       e_req, e_fs, e_hs, e_vs;
    logic [1:0] e_x, e_y, e_b;
    logic [2:0] e_r, e_g;

    always @(posedge clk) begin
        int mx, my;
        cyc++;
        if (rst) begin
            m_run = 0; m_pos = 0; m_act = 0; m_hsy = 0; m_vsy = 0;
            e_req = 0; e_fs = 0; e_x = 0; e_y = 0; e_r = 0; e_g = 0; e_b = 0; e_hs = 1; e_vs = 1;
        end else if (!m_run) begin
            e_req = 0; e_fs = 0; e_r = 0; e_g = 0; e_b = 0; e_hs = 1; e_vs = 1;
            m_act = 0; m_hsy = 0; m_vsy = 0;
            if (en) m_run = 1;
        end else begin
            mx = m_pos % HT;
            my = m_pos / HT;
            e_r  = m_act ? pd[7:5] : 3'd0;
            e_g  = m_act ? pd[4:2] : 3'd0;
            e_b  = m_act ? pd[1:0] : 2'd0;
            e_hs = !m_hsy;
            e_vs = !m_vsy;
            m_act = (mx < HA) && (my < VA);
            m_hsy = (mx >= HA + HF) && (mx < HA + HF + HSY);
            m_vsy = (my >= VA + VF) && (my < VA + VF + VSY);
            e_req = m_act;
            e_x   = mx[1:0];
            e_y   = my[1:0];
            e_fs  = (m_pos == 0);
            m_pos++;
            if (m_pos == HT * VT) begin
                m_pos = 0;
                if (!m_enp && !en) m_run = 0;
            end
        end
        m_enp = en;
    end

    task test_reset();
        rst = 1; en = 1; en2 = 1; pd = 8'hFF; pd2 = 8'hFF;
        repeat (3) @(negedge clk);
        checks++;
        if ({req, fs, px, py, r, g, b, hs, vs} !== {2'b00, 4'd0, 8'd0, 2'b11}) begin
            failures++;
            $display("FAIL reset_small got req=%b fs=%b xy=%0d,%0d rgb=%0d/%0d/%0d hs=%b vs=%b want zeros hs=vs=1",
                     req, fs, px, py, r, g, b, hs, vs);
        end
        checks++;
        if ({req2, fs2, px2, py2, r2, g2, b2, hs2, vs2} !== {2'b00, 19'd0, 8'd0, 2'b11}) begin
            failures++;
            $display("FAIL reset_dflt got req=%b fs=%b xy=%0d,%0d rgb=%0d/%0d/%0d hs=%b vs=%b want zeros hs=vs=1",
                     req2, fs2, px2, py2, r2, g2, b2, hs2, vs2);
        end
        rst = 0; en = 0; en2 = 0;
        @(negedge clk);
    endtask

    task test_scan();
        int nreq, last_fs, hs_low;
        bit seen_fs;
        nreq = 0; last_fs = 0; hs_low = 0; seen_fs = 0;
        en = 1;
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            checks++;
            if ({req, fs, r, g, b, hs, vs} !== {e_req, e_fs, e_r, e_g, e_b, e_hs, e_vs} || (e_req && {px, py} !== {e_x, e_y})) begin
                failures++;
                $display("FAIL scan cyc=%0d got req=%b fs=%b xy=%0d,%0d rgb=%0d/%0d/%0d hs=%b vs=%b want req=%b fs=%b xy=%0d,%0d rgb=%0d/%0d/%0d hs=%b vs=%b",
                         cyc, req, fs, px, py, r, g, b, hs, vs, e_req, e_fs, e_x, e_y, e_r, e_g, e_b, e_hs, e_vs);
            end
            if (fs) begin
                if (seen_fs) begin
                    checks += 2;
                    if (nreq !== 12) begin failures++; $display("FAIL reqs_per_frame got %0d want 12", nreq); end
                    if (cyc - last_fs !== 48) begin failures++; $display("FAIL frame_period got %0d want 48", cyc - last_fs); end
                end
                seen_fs = 1; last_fs = cyc; nreq = 0;
            end
            if (req) nreq++;
            if (!hs) hs_low++;
            else if (hs_low != 0) begin
                checks++;
                if (hs_low !== 2) begin failures++; $display("FAIL hs_width got %0d want 2", hs_low); end
                hs_low = 0;
            end
            pd = 8'($urandom);
        end
    endtask

    task test_const_colour();
        logic prev_req;
        prev_req = req;
        en = 1; pd = 8'hE3;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            checks += 2;
            if ({req, fs, r, g, b, hs, vs} !== {e_req, e_fs, e_r, e_g, e_b, e_hs, e_vs} || (e_req && {px, py} !== {e_x, e_y})) begin
                failures++;
                $display("FAIL const_model cyc=%0d got req=%b rgb=%0d/%0d/%0d hs=%b vs=%b want req=%b rgb=%0d/%0d/%0d hs=%b vs=%b",
                         cyc, req, r, g, b, hs, vs, e_req, e_r, e_g, e_b, e_hs, e_vs);
            end
            if ({r, g, b} !== (prev_req ? {3'd7, 3'd0, 2'd3} : 8'd0)) begin
                failures++;
                $display("FAIL const_colour cyc=%0d got rgb=%0d/%0d/%0d after_req=%b want 7/0/3 after a request else 0",
                         cyc, r, g, b, prev_req);
            end
            prev_req = req;
        end
    endtask

    task test_drain();
        bit found;
        int nafter;
        logic [1:0] lx, ly;
        found = 0; nafter = 0; lx = 0; ly = 0;
        en = 1;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            checks++;
            if ({req, fs, r, g, b, hs, vs} !== {e_req, e_fs, e_r, e_g, e_b, e_hs, e_vs} || (e_req && {px, py} !== {e_x, e_y})) begin
                failures++;
                $display("FAIL drain_model cyc=%0d got req=%b xy=%0d,%0d hs=%b vs=%b want req=%b xy=%0d,%0d hs=%b vs=%b",
                         cyc, req, px, py, hs, vs, e_req, e_x, e_y, e_hs, e_vs);
            end
            if (req && px == 2'd2 && py == 2'd1) begin found = 1; en = 0; end
            pd = 8'($urandom);
        end
        checks++;
        if (!found) begin failures++; $display("FAIL drain_start got no request at (2,1) want one within 100 cycles"); end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            checks++;
            if ({req, fs, r, g, b, hs, vs} !== {e_req, e_fs, e_r, e_g, e_b, e_hs, e_vs} || (e_req && {px, py} !== {e_x, e_y})) begin
                failures++;
                $display("FAIL drain_model cyc=%0d got req=%b xy=%0d,%0d hs=%b vs=%b want req=%b xy=%0d,%0d hs=%b vs=%b",
                         cyc, req, px, py, hs, vs, e_req, e_x, e_y, e_hs, e_vs);
            end
            if (req) begin nafter++; lx = px; ly = py; end
            pd = 8'($urandom);
        end
        checks += 3;
        if (nafter !== 5) begin failures++; $display("FAIL drain_count got %0d want 5", nafter); end
        if ({lx, ly} !== {2'd3, 2'd2}) begin failures++; $display("FAIL drain_last got (%0d,%0d) want (3,2)", lx, ly); end
        if ({req, fs, r, g, b, hs, vs} !== {2'b00, 8'd0, 2'b11}) begin
            failures++;
            $display("FAIL drain_idle got req=%b fs=%b rgb=%0d/%0d/%0d hs=%b vs=%b want zeros hs=vs=1", req, fs, r, g, b, hs, vs);
        end
    endtask

    task test_reenable();
        int t0;
        bit got;
        got = 0; t0 = 0;
        en = 1;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (fs) begin got = 1; t0 = cyc; end
        end
        checks++;
        if (!got) begin failures++; $display("FAIL reenable_start got no FrameStart want one within 10 cycles"); end
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            checks++;
            if ({req, fs, r, g, b, hs, vs} !== {e_req, e_fs, e_r, e_g, e_b, e_hs, e_vs} || (e_req && {px, py} !== {e_x, e_y})) begin
                failures++;
                $display("FAIL reenable_model cyc=%0d got req=%b fs=%b xy=%0d,%0d want req=%b fs=%b xy=%0d,%0d",
                         cyc, req, fs, px, py, e_req, e_fs, e_x, e_y);
            end
            if (fs) begin
                got = 1;
                checks++;
                if (cyc - t0 !== 48) begin failures++; $display("FAIL reenable_period got %0d want 48", cyc - t0); end
            end
            en = !(i >= 5 && i < 15);
            pd = 8'($urandom);
        end
        if (!got) begin checks++; failures++; $display("FAIL reenable_gap got no second FrameStart want one after 48 cycles"); end
    endtask

    task test_reset_midframe();
        bit found, got;
        found = 0; got = 0;
        en = 1;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (req && px == 2'd3) begin found = 1; rst = 1; end
        end
        checks++;
        if (!found) begin failures++; $display("FAIL midreset_start got no request at x=3 want one within 60 cycles"); end
        @(negedge clk);
        checks++;
        if ({req, fs, px, py, r, g, b, hs, vs} !== {2'b00, 4'd0, 8'd0, 2'b11}) begin
            failures++;
            $display("FAIL midreset_clear got req=%b fs=%b xy=%0d,%0d rgb=%0d/%0d/%0d hs=%b vs=%b want zeros hs=vs=1",
                     req, fs, px, py, r, g, b, hs, vs);
        end
        rst = 0;
        for (int i = 0; i < 5 && !got; i++) begin
            @(negedge clk);
            if (req) begin
                got = 1;
                checks++;
                if ({px, py, fs} !== {2'd0, 2'd0, 1'b1}) begin
                    failures++;
                    $display("FAIL midreset_restart got (%0d,%0d) fs=%b want (0,0) fs=1", px, py, fs);
                end
            end
        end
        if (!got) begin checks++; failures++; $display("FAIL midreset_restart got no request want one within 5 cycles"); end
    endtask

    task test_random();
        for (int i = 0; i < 1200; i++) begin
            en  = ($urandom_range(0, 9) < 7);
            rst = ($urandom_range(0, 199) == 0);
            pd  = 8'($urandom);
            @(negedge clk);
            checks++;
            if ({req, fs, r, g, b, hs, vs} !== {e_req, e_fs, e_r, e_g, e_b, e_hs, e_vs} || (e_req && {px, py} !== {e_x, e_y})) begin
                failures++;
                $display("FAIL random cyc=%0d got req=%b fs=%b xy=%0d,%0d rgb=%0d/%0d/%0d hs=%b vs=%b want req=%b fs=%b xy=%0d,%0d rgb=%0d/%0d/%0d hs=%b vs=%b",
                         cyc, req, fs, px, py, r, g, b, hs, vs, e_req, e_fs, e_x, e_y, e_r, e_g, e_b, e_hs, e_vs);
            end
        end
        rst = 0; en = 0;
    endtask

    task test_default_timing();
        bit got;
        int t1;
        logic exp_req;
        got = 0; t1 = 0;
        pd2 = 8'h5A; en2 = 1;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (req2) got = 1;
        end
        checks++;
        if (!got) begin failures++; $display("FAIL div_first got no request want one within 10 cycles"); end
        else if ({px2, py2, fs2} !== {10'd0, 9'd0, 1'b1}) begin
            failures++; $display("FAIL div_first got (%0d,%0d) fs=%b want (0,0) fs=1", px2, py2, fs2);
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            exp_req = (k % 2 == 0);
            checks++;
            if (req2 !== exp_req || (exp_req && px2 !== 10'(k / 2))) begin
                failures++; $display("FAIL div_alternate k=%0d got req=%b x=%0d want req=%b x=%0d", k, req2, px2, exp_req, k / 2);
            end
            if (k >= 2) begin
                checks++;
                if ({r2, g2, b2} !== 8'h5A) begin
                    failures++; $display("FAIL div_colour k=%0d got %h want 5a", k, {r2, g2, b2});
                end
            end
        end
        got = 0;
        for (int i = 0; i < 4000 && !got; i++) begin
            @(negedge clk);
            if (!hs2) begin got = 1; t1 = cyc; end
        end
        checks++;
        if (!got) begin failures++; $display("FAIL hs_fall got none want one within 4000 cycles"); end
        got = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (hs2) begin
                got = 1;
                checks++;
                if (cyc - t1 !== 192) begin failures++; $display("FAIL hs_pulse got %0d want 192", cyc - t1); end
            end
        end
        if (!got) begin checks++; failures++; $display("FAIL hs_pulse got no rise want one within 400 cycles"); end
        got = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (!hs2) begin
                got = 1;
                checks++;
                if (cyc - t1 !== 1600) begin failures++; $display("FAIL line_period got %0d want 1600", cyc - t1); end
            end
        end
        if (!got) begin checks++; failures++; $display("FAIL line_period got no next fall want one within 2000 cycles"); end
        en2 = 0;
    endtask

    initial begin
        rst = 1; en = 0; en2 = 0; pd = 8'h00; pd2 = 8'h00;
        test_reset();
        test_scan();
        test_const_colour();
        test_drain();
        test_reenable();
        test_reset_midframe();
        test_random();
        test_default_timing();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_scan_gen.md
VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

Interface
REQ-001 Parameters SHALL be H_ACTIVE=640, H_FP=16, H_SYNC=96, H_BP=48, V_ACTIVE=480, V_FP=10, V_SYNC=2, V_BP=33: standard timing, in pixels and lines.
REQ-002 Parameters SHALL be HS_POL=0, VS_POL=0: sync active level, 0 = active-low.
REQ-003 Parameters SHALL be RW=3, GW=3, BW=2: colour channel widths.
REQ-004 Parameter PIX_DIV=2 SHALL set Clk cycles per pixel, legal range 1..16.
REQ-005 Clk  in  1  sole clock; one clock, all logic rising-edge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 Enable  in  1  request scanning; level-sensitive.
REQ-008 PixelData  in  RW+GW+BW  {R,G,B} for the pixel requested one tick earlier.
REQ-009 PixelReq  out  1  pixel fetch strobe, one Clk wide.
REQ-010 PixelX/PixelY  out  $clog2(H_ACTIVE)/$clog2(V_ACTIVE)  coordinates of the requested pixel.
REQ-011 Red/Green/Blue  out  RW/GW/BW  colour outputs.
REQ-012 HS/VS  out  1  sync outputs.
REQ-013 FrameStart  out  1  one-Clk pulse at the first request of each frame.

Function
REQ-014 Pixel tick: divider 0..PIX_DIV-1 SHALL tick when it reaches PIX_DIV-1; PIX_DIV=1 SHALL tick every cycle.
REQ-015 H_TOTAL and V_TOTAL SHALL be the sums of their four parameters; counter widths SHALL be $clog2 of those totals.
REQ-016 On each tick, hcnt SHALL wrap at H_TOTAL-1 to 0; vcnt SHALL advance only on hcnt wrap and wrap at V_TOTAL-1.
REQ-017 Active region SHALL be hcnt<H_ACTIVE and vcnt<V_ACTIVE.
REQ-018 hsync SHALL be true for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC; vsync SHALL follow the same rule on vcnt.
REQ-019 Stage 1, on a tick in RUN/DRAIN: PixelReq SHALL pulse for that cycle only when active; PixelX/PixelY SHALL equal hcnt/vcnt; active and sync flags SHALL be registered.
REQ-020 Stage 2, on the next tick: Red/Green/Blue SHALL take PixelData slices when the delayed active flag is set, else 0; HS/VS SHALL take the delayed sync XNOR polarity.
REQ-021 Latency SHALL be exactly one pixel tick from PixelReq to the colour at the outputs, with syncs aligned to colour.
REQ-022 FrameStart SHALL pulse together with PixelReq at (0,0).
REQ-023 FSM state IDLE: counters held at (0,0), divider held, no requests, colour 0, HS/VS inactive level; Enable=1 SHALL move the FSM to RUN on the next Clk.
REQ-024 FSM state RUN: scan continuously; Enable=0 SHALL move the FSM to DRAIN.
REQ-025 FSM state DRAIN: scan continues to the end of the current frame; on wrap to (0,0) the FSM SHALL go to IDLE.
REQ-026 Enable re-asserted during DRAIN SHALL return the FSM to RUN without a frame break.
REQ-027 A frame SHALL never be truncated by Enable.
REQ-028 Enable toggling within one frame SHALL have no visible effect.
REQ-029 PixelData SHALL be sampled only on a stage-2 tick; its value between ticks SHALL be ignored.

Reset
REQ-030 Reset SHALL override all other inputs in the same cycle.
REQ-031 Reset SHALL force FSM=IDLE and clear counters and divider.
REQ-032 Reset SHALL drive PixelReq=0, FrameStart=0, PixelX/PixelY=0 and colour=0.
REQ-033 Reset SHALL drive HS=~HS_POL and VS=~VS_POL.
REQ-034 Reset mid-frame SHALL abort immediately; the next Enable SHALL restart the scan at (0,0).

Structure
REQ-035 Package vga_pkg SHALL hold the FSM state enum and the 640x480 default timing constants.
REQ-036 Sub-module vga_axis_counter SHALL be instantiated twice (horizontal, vertical), parametrised by ACTIVE/FP/SYNC/BP, outputting count, active, sync and wrap.

Verification
REQ-037 Small timing (H 4/1/2/1, V 3/1/1/1, PIX_DIV=1, Enable=1) SHALL give PixelReq 4 of every 8 cycles.
REQ-038 The same setup SHALL give HS low for 2 cycles starting 2 cycles after the last request of a line, 12 requests per frame, and FrameStart every 48 cycles.
REQ-039 PixelData=8'hE3 held constant SHALL give Red=7, Green=0, Blue=3 exactly 1 cycle after each PixelReq, and all zeros during blanking.
REQ-040 PIX_DIV=2 with the default timing SHALL give PixelReq on alternate cycles, HS pulse width 192 Clk and line period 1600 Clk.
REQ-041 Enable dropped at (2,1) SHALL let the frame complete to request (3,2), then enter IDLE with outputs 0 and syncs inactive; Enable re-raised during DRAIN SHALL show no gap in FrameStart period.
REQ-042 Reset asserted at hcnt=3 SHALL clear all outputs on the next Clk; after Reset release with Enable=1, the first PixelReq SHALL be at (0,0) with FrameStart.
